// File: rtl/matrix_pkg.sv
// Shared sizing, RGB444 field layout and swap FSM encoding for the HUB75 pixel source.
package matrix_pkg;

    localparam int DEF_COL_BITS   = 5;
    localparam int DEF_ROW_BITS   = 4;
    localparam int DEF_PLANE_BITS = 2;

    localparam int RGB_W  = 12;
    localparam int CHAN_W = 4;
    localparam int R_LSB  = 8;
    localparam int G_LSB  = 4;
    localparam int B_LSB  = 0;

    typedef enum logic {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_t;

    // One BCM bit of one colour channel of an RGB444 word.
    function automatic logic chan_bit(input logic [RGB_W-1:0] rgb, input int lsb, input int plane);
        logic [CHAN_W-1:0] field;
        field = rgb[lsb +: CHAN_W];
        return field[plane[1:0]];
    endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// Single-write, single-read framebuffer bank with a registered read port.
module fb_bank_ram #(
    parameter int AW = 10,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          re,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/matrix_pixel_fetch.sv
// Double-buffered RGB444 framebuffer feeding one BCM bit per colour per panel half
// to the matrix driver, with a frame-synchronous front/back swap.
module matrix_pixel_fetch #(
    parameter int COL_BITS   = matrix_pkg::DEF_COL_BITS,
    parameter int ROW_BITS   = matrix_pkg::DEF_ROW_BITS,
    parameter int PLANE_BITS = matrix_pkg::DEF_PLANE_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ROW_BITS:0]     wr_row,
    input  logic [COL_BITS-1:0]   wr_col,
    input  logic [11:0]           wr_rgb,
    input  logic                  swap_req,
    output logic                  swap_done,
    input  logic                  frame_start,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ROW_BITS-1:0]   req_row,
    input  logic [COL_BITS-1:0]   req_col,
    input  logic [PLANE_BITS-1:0] req_plane,
    output logic                  pix_valid,
    output logic [1:0]            pix_r,
    output logic [1:0]            pix_g,
    output logic [1:0]            pix_b
);
    import matrix_pkg::*;

    localparam int AW = 1 + ROW_BITS + COL_BITS;

    logic                  ready_reg;
    logic                  front_reg;
    swap_state_t           state_reg, state_next;
    logic                  swap_now;
    logic                  accept;
    logic                  s1_valid_reg;
    logic [PLANE_BITS-1:0] plane_reg;
    logic                  pix_valid_reg;
    logic [1:0]            pix_r_reg, pix_g_reg, pix_b_reg;
    logic [1:0]            pix_r_next, pix_g_next, pix_b_next;
    logic [AW-1:0]         wr_addr, rd_addr;
    logic [RGB_W-1:0]      bank_data [2];

    assign accept  = req_valid && ready_reg;
    // Buffer index sits in the address MSB; writes always target the back buffer.
    assign wr_addr = {~front_reg, wr_row[ROW_BITS-1:0], wr_col};
    assign rd_addr = {front_reg, req_row, req_col};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_half
            logic bank_we;
            assign bank_we = wr_en && ((gi == 1) ? wr_row[ROW_BITS] : !wr_row[ROW_BITS]);

            fb_bank_ram #(
                .AW(AW),
                .DW(RGB_W)
            ) u_bank (
                .clk    (clk),
                .we     (bank_we),
                .wr_addr(wr_addr),
                .wr_data(wr_rgb),
                .re     (accept),
                .rd_addr(rd_addr),
                .rd_data(bank_data[gi])
            );
        end
    endgenerate

    // A swap requested in the same cycle as frame_start happens immediately.
    always_comb begin
        state_next = state_reg;
        swap_now   = 1'b0;
        case (state_reg)
            SWAP_IDLE: begin
                if (swap_req && ready_reg) begin
                    if (frame_start) begin
                        swap_now = 1'b1;
                    end else begin
                        state_next = SWAP_PENDING;
                    end
                end
            end
            SWAP_PENDING: begin
                if (frame_start) begin
                    swap_now   = 1'b1;
                    state_next = SWAP_IDLE;
                end
            end
            default: state_next = SWAP_IDLE;
        endcase
    end

    always_comb begin
        pix_r_next = {chan_bit(bank_data[1], R_LSB, int'(plane_reg)),
                      chan_bit(bank_data[0], R_LSB, int'(plane_reg))};
        pix_g_next = {chan_bit(bank_data[1], G_LSB, int'(plane_reg)),
                      chan_bit(bank_data[0], G_LSB, int'(plane_reg))};
        pix_b_next = {chan_bit(bank_data[1], B_LSB, int'(plane_reg)),
                      chan_bit(bank_data[0], B_LSB, int'(plane_reg))};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_reg     <= 1'b0;
            front_reg     <= 1'b0;
            state_reg     <= SWAP_IDLE;
            s1_valid_reg  <= 1'b0;
            plane_reg     <= '0;
            pix_valid_reg <= 1'b0;
            pix_r_reg     <= '0;
            pix_g_reg     <= '0;
            pix_b_reg     <= '0;
        end else begin
            ready_reg    <= 1'b1;
            state_reg    <= state_next;
            s1_valid_reg <= accept;
            if (swap_now) begin
                front_reg <= ~front_reg;
            end
            if (accept) begin
                plane_reg <= req_plane;
            end
            pix_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                pix_r_reg <= pix_r_next;
                pix_g_reg <= pix_g_next;
                pix_b_reg <= pix_b_next;
            end
        end
    end

    assign req_ready = ready_reg;
    assign swap_done = swap_now;
    assign pix_valid = pix_valid_reg;
    assign pix_r     = pix_r_reg;
    assign pix_g     = pix_g_reg;
    assign pix_b     = pix_b_reg;

endmodule

// File: tb/tb_matrix_pixel_fetch.sv
// Scoreboard bench for matrix_pixel_fetch: a framebuffer model predicts each response and its cycle.
module tb_matrix_pixel_fetch;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_row = '0;
    logic [4:0] wr_col = '0;
    logic [11:0] wr_rgb = '0;
    logic       swap_req = 1'b0;
    logic       swap_done;
    logic       frame_start = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_row = '0;
    logic [4:0] req_col = '0;
    logic [1:0] req_plane = '0;
    logic       pix_valid;
    logic [1:0] pix_r, pix_g, pix_b;

    matrix_pixel_fetch dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_rgb(wr_rgb),
        .swap_req(swap_req), .swap_done(swap_done), .frame_start(frame_start),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_row(req_row), .req_col(req_col), .req_plane(req_plane),
        .pix_valid(pix_valid), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    // mem_m[buffer][half][pair][col]
    logic [11:0] mem_m [0:1][0:1][0:15][0:31];
    logic        front_m = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            checks++;
            if (pix_valid !== 1'b1 || pix_r !== e.r || pix_g !== e.g || pix_b !== e.b) begin
                failures++;
                $display("FAIL pix_resp cyc=%0d got v=%b r=%b g=%b b=%b need v=1 r=%b g=%b b=%b",
                         cyc, pix_valid, pix_r, pix_g, pix_b, e.r, e.g, e.b);
            end else begin
                $display("resp cyc=%0d r=%b g=%b b=%b ok", cyc, pix_r, pix_g, pix_b);
            end
        end else if (pix_valid !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL pix_unexpected cyc=%0d got pix_valid=%b need 0", cyc, pix_valid);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input logic [4:0] row, input logic [4:0] col, input logic [11:0] rgb);
        wr_en  = 1'b1;
        wr_row = row;
        wr_col = col;
        wr_rgb = rgb;
        mem_m[!front_m][row[4]][row[3:0]][col] = rgb;
        $display("write row=%0d col=%0d rgb=%h buf=%0d", row, col, rgb, !front_m);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_req(input logic [3:0] row, input logic [4:0] col, input logic [1:0] p);
        exp_t e;
        logic [11:0] tv, bv;
        int pi;
        pi = int'(p);
        tv = mem_m[front_m][0][row][col];
        bv = mem_m[front_m][1][row][col];
        e.due = cyc + 2;
        e.r = {bv[8 + pi], tv[8 + pi]};
        e.g = {bv[4 + pi], tv[4 + pi]};
        e.b = {bv[pi], tv[pi]};
        sb.push_back(e);
        req_valid = 1'b1;
        req_row   = row;
        req_col   = col;
        req_plane = p;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic swap_event(input logic req, input logic fs, input logic exp_done, input string name);
        swap_req    = req;
        frame_start = fs;
        #1;
        checks++;
        if (swap_done !== exp_done) begin
            failures++;
            $display("FAIL %s got swap_done=%b need %b", name, swap_done, exp_done);
        end else begin
            $display("swap %s req=%b fs=%b swap_done=%b", name, req, fs, swap_done);
        end
        tick();
        if (exp_done) front_m = !front_m;
        swap_req    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks += 5;
        if (pix_valid !== 1'b0) begin failures++; $display("FAIL rst_pix_valid got %b need 0", pix_valid); end
        if ({pix_r, pix_g, pix_b} !== 6'b0) begin failures++; $display("FAIL rst_pix got %b need 000000", {pix_r, pix_g, pix_b}); end
        if (swap_done !== 1'b0) begin failures++; $display("FAIL rst_swap_done got %b need 0", swap_done); end
        if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got %b need 0", req_ready); end
        rst = 1'b1;
        tick();
        if (req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_rst got %b need 1", req_ready); end
        $display("reset released req_ready=%b", req_ready);
    endtask

    task automatic prime_buffers();
        for (int k = 0; k < 2; k++) begin
            write_px(5'd0, 5'd0, 12'h000);
            write_px(5'd16, 5'd0, 12'h000);
            write_px(5'd5, 5'd7, 12'h000);
            write_px(5'd21, 5'd7, 12'h000);
            swap_event(1'b1, 1'b1, 1'b1, "prime_swap");
        end
    endtask

    task automatic test_basic();
        write_px(5'd0, 5'd0, 12'hF00);
        write_px(5'd16, 5'd0, 12'h00F);
        swap_event(1'b1, 1'b1, 1'b1, "basic_swap");
        do_req(4'd0, 5'd0, 2'd3);
        drain();
        checks++;
        if (pix_r !== 2'b01 || pix_g !== 2'b00 || pix_b !== 2'b10) begin
            failures++;
            $display("FAIL basic_const got r=%b g=%b b=%b need r=01 g=00 b=10", pix_r, pix_g, pix_b);
        end
    endtask

    task automatic test_planes();
        write_px(5'd5, 5'd7, 12'hA50);
        write_px(5'd21, 5'd7, 12'h000);
        swap_event(1'b1, 1'b1, 1'b1, "planes_swap");
        for (int p = 0; p < 4; p++) do_req(4'd5, 5'd7, 2'(p));
        drain();
        checks++;
        if (pix_r !== 2'b01 || pix_g !== 2'b00) begin
            failures++;
            $display("FAIL planes_hold got r=%b g=%b need r=01 g=00", pix_r, pix_g);
        end
    endtask

    task automatic test_pending();
        write_px(5'd5, 5'd7, 12'h5A0);
        swap_event(1'b1, 1'b0, 1'b0, "pend_req");
        for (int i = 0; i < 100; i++) begin
            checks++;
            if (swap_done !== 1'b0) begin
                failures++;
                $display("FAIL pend_no_swap i=%0d got swap_done=%b need 0", i, swap_done);
            end
            if (i % 10 == 0) do_req(4'd5, 5'd7, 2'(i / 10));
            else tick();
        end
        swap_event(1'b0, 1'b1, 1'b1, "pend_frame");
        swap_event(1'b0, 1'b0, 1'b0, "pend_after");
        do_req(4'd5, 5'd7, 2'd1);
        drain();
    endtask

    task automatic test_same_cycle();
        swap_event(1'b1, 1'b1, 1'b1, "same_cycle");
        swap_event(1'b1, 1'b0, 1'b0, "dbl_req1");
        swap_event(1'b1, 1'b0, 1'b0, "dbl_req2");
        swap_event(1'b0, 1'b1, 1'b1, "dbl_frame");
        swap_event(1'b0, 1'b1, 1'b0, "dbl_frame2");
        do_req(4'd5, 5'd7, 2'd0);
        do_req(4'd0, 5'd0, 2'd3);
        drain();
    endtask

    task automatic test_no_tear();
        for (int i = 0; i < 8; i++) begin
            wr_en  = 1'b1;
            wr_row = (i % 2 == 0) ? 5'd5 : 5'd21;
            wr_col = 5'd7;
            wr_rgb = 12'($urandom);
            mem_m[!front_m][wr_row[4]][wr_row[3:0]][wr_col] = wr_rgb;
            do_req(4'd5, 5'd7, 2'(i % 4));
        end
        wr_en = 1'b0;
        drain();
    endtask

    task automatic test_reset_inflight();
        do_req(4'd0, 5'd0, 2'd3);
        do_req(4'd0, 5'd0, 2'd3);
        rst = 1'b0;
        #1;
        sb.delete();
        front_m = 1'b0;
        checks += 2;
        if (pix_valid !== 1'b0) begin failures++; $display("FAIL inflight_rst_valid got %b need 0", pix_valid); end
        if (req_ready !== 1'b0) begin failures++; $display("FAIL inflight_rst_ready got %b need 0", req_ready); end
        $display("reset asserted with requests in flight");
        repeat (2) tick();
        rst = 1'b1;
        repeat (6) tick();
        do_req(4'd0, 5'd0, 2'd3);
        drain();
    endtask

    initial begin
        for (int a = 0; a < 2; a++)
            for (int h = 0; h < 2; h++)
                for (int r = 0; r < 16; r++)
                    for (int c = 0; c < 32; c++)
                        mem_m[a][h][r][c] = '0;
        test_reset();
        prime_buffers();
        test_basic();
        test_planes();
        test_pending();
        test_same_cycle();
        test_no_tear();
        test_reset_inflight();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_empty got %0d outstanding need 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
